// File: rtl/sq_sqrt_unit_if.sv
// Operand/result bundle between the decode/hazard logic and sq_sqrt_unit.
// master drives operands and start; slave returns result and busy.
interface sq_sqrt_unit_if;
   logic [7:0]  a_i;
   logic [7:0]  b_i;
   logic        start_i;
   logic [23:0] y_o;
   logic        busy_o;

   modport master (
      output a_i, b_i, start_i,
      input  y_o, busy_o
   );

   modport slave (
      input  a_i, b_i, start_i,
      output y_o, busy_o
   );
endinterface

// File: rtl/sq_sqrt_unit.sv
// Multicycle y = a*a + floor(sqrt(b)): shift-add squarer, bit-serial root, adder.
// Build macro SQ_SQRT_UNIT_SQRT_EN enables the root path (13 cycles); else y = a*a (9 cycles).
module sq_sqrt_unit (
   input  logic         clk_i,
   input  logic         rst_i,
   sq_sqrt_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_SQRT,
      S_SUM
   } state_t;

   state_t      state_q;
   logic [15:0] mcand_q;
   logic [7:0]  mplier_q;
   logic [15:0] prod_q;
   logic [15:0] prod_d;
   logic [2:0]  cnt_q;
   logic        busy_q;
   logic [23:0] y_q;

`ifdef SQ_SQRT_UNIT_SQRT_EN
   logic [7:0]  x_q;
   logic [7:0]  root_q;
   logic [7:0]  mask_q;
   logic [7:0]  x_d;
   logic [7:0]  root_d;
   logic [7:0]  trial;

   // One root step: try setting the current mask bit in the partial root.
   always_comb begin
      trial  = root_q | mask_q;
      x_d    = x_q;
      root_d = root_q >> 1;
      if (x_q >= trial) begin
         x_d    = x_q - trial;
         root_d = (root_q >> 1) | mask_q;
      end
   end
`else
   logic unused_b;
   assign unused_b = ^bus.b_i;
`endif

   // One squarer step: accumulate the multiplicand when the multiplier LSB is set.
   always_comb begin
      prod_d = prod_q;
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
   end

   // Sequencer and datapath registers; outputs are registered here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         y_q      <= '0;
`ifdef SQ_SQRT_UNIT_SQRT_EN
         x_q      <= '0;
         root_q   <= '0;
         mask_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  mcand_q  <= {8'b0, bus.a_i};
                  mplier_q <= bus.a_i;
                  prod_q   <= '0;
                  cnt_q    <= '0;
`ifdef SQ_SQRT_UNIT_SQRT_EN
                  x_q      <= bus.b_i;
                  root_q   <= '0;
                  mask_q   <= 8'h40;
`endif
                  busy_q   <= 1'b1;
                  state_q  <= S_MUL;
               end
            end
            S_MUL: begin
               prod_q   <= prod_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
`ifdef SQ_SQRT_UNIT_SQRT_EN
                  state_q <= S_SQRT;
`else
                  state_q <= S_SUM;
`endif
               end
            end
`ifdef SQ_SQRT_UNIT_SQRT_EN
            S_SQRT: begin
               x_q    <= x_d;
               root_q <= root_d;
               mask_q <= mask_q >> 2;
               if (mask_q == 8'h01) state_q <= S_SUM;
            end
`endif
            S_SUM: begin
`ifdef SQ_SQRT_UNIT_SQRT_EN
               y_q <= {8'b0, prod_q} + {20'b0, root_q[3:0]};
`else
               y_q <= {8'b0, prod_q};
`endif
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.y_o    = y_q;
   assign bus.busy_o = busy_q;

endmodule
